// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU + non-overlapping max-pool over a raster-order, channel-interleaved feature map.
// Keeps one pooled row of running maxima per channel; each pooled element appears one cycle after its window's last input.
module relu_maxpool_stream #(
  parameter int Data_W  = 8,
  parameter int In_Dim  = 2,
  parameter int Ch      = 1,
  parameter int Pool    = 2,
  parameter int Relu_En = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [Data_W-1:0] in_data,
  output logic              out_valid,
  output logic [Data_W-1:0] out_data,
  output logic              out_frame_last
);

  localparam int OUT_P = In_Dim / Pool;
  localparam int BUF_N = (OUT_P * Ch > 0) ? OUT_P * Ch : 1;
  localparam int CH_W  = (Ch > 1) ? $clog2(Ch) : 1;
  localparam int DIM_W = $clog2(In_Dim + 1);
  localparam int WIN_W = (Pool > 1) ? $clog2(Pool) : 1;
  localparam int IDX_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(Ch - 1);
  localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(In_Dim - 1);
  localparam logic [DIM_W-1:0] OUT_P_V  = DIM_W'(OUT_P);
  localparam logic [DIM_W-1:0] P_LAST   = DIM_W'(OUT_P - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(Pool - 1);

  // Raster position plus its decomposition into pooled index and offset within the window,
  // tracked incrementally so no divider is needed.
  logic [CH_W-1:0]  ch_q,   ch_d;
  logic [DIM_W-1:0] col_q,  col_d;
  logic [DIM_W-1:0] row_q,  row_d;
  logic [WIN_W-1:0] cwin_q, cwin_d;
  logic [WIN_W-1:0] rwin_q, rwin_d;
  logic [DIM_W-1:0] pcol_q, pcol_d;
  logic [DIM_W-1:0] prow_q, prow_d;

  logic              out_valid_q, out_valid_d;
  logic [Data_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;

  logic signed [Data_W-1:0] buf_q [BUF_N];

  logic [IDX_W-1:0]         idx;
  logic                     in_win;
  logic                     first_el;
  logic                     last_el;
  logic signed [Data_W-1:0] v_s;
  logic signed [Data_W-1:0] entry_s;
  logic signed [Data_W-1:0] max_s;
  logic signed [Data_W-1:0] pooled_s;

  assign idx      = IDX_W'(int'(pcol_q) * Ch + int'(ch_q));
  assign in_win   = (pcol_q < OUT_P_V) && (prow_q < OUT_P_V);
  assign first_el = (cwin_q == '0) && (rwin_q == '0);
  assign last_el  = (cwin_q == WIN_LAST) && (rwin_q == WIN_LAST);

  always_comb begin
    v_s      = $signed(in_data);
    if ((Relu_En != 0) && in_data[Data_W-1]) begin
      v_s = '0;
    end
    entry_s  = buf_q[idx];
    max_s    = (entry_s > v_s) ? entry_s : v_s;
    pooled_s = first_el ? v_s : max_s;
  end

  always_comb begin
    ch_d   = ch_q;
    col_d  = col_q;
    row_d  = row_q;
    cwin_d = cwin_q;
    rwin_d = rwin_q;
    pcol_d = pcol_q;
    prow_d = prow_q;
    if (in_valid) begin
      if (ch_q == CH_LAST) begin
        ch_d = '0;
        if (col_q == DIM_LAST) begin
          col_d  = '0;
          cwin_d = '0;
          pcol_d = '0;
          if (row_q == DIM_LAST) begin
            row_d  = '0;
            rwin_d = '0;
            prow_d = '0;
          end else begin
            row_d = row_q + 1'b1;
            if (rwin_q == WIN_LAST) begin
              rwin_d = '0;
              prow_d = prow_q + 1'b1;
            end else begin
              rwin_d = rwin_q + 1'b1;
            end
          end
        end else begin
          col_d = col_q + 1'b1;
          if (cwin_q == WIN_LAST) begin
            cwin_d = '0;
            pcol_d = pcol_q + 1'b1;
          end else begin
            cwin_d = cwin_q + 1'b1;
          end
        end
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = in_valid && in_win && last_el;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    if (out_valid_d) begin
      out_data_d = pooled_s;
      out_last_d = (ch_q == CH_LAST) && (pcol_q == P_LAST) && (prow_q == P_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      cwin_q      <= '0;
      rwin_q      <= '0;
      pcol_q      <= '0;
      prow_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cwin_q      <= cwin_d;
      rwin_q      <= rwin_d;
      pcol_q      <= pcol_d;
      prow_q      <= prow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // No reset needed: the first element of every window overwrites its entry.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && in_win) begin
      buf_q[idx] <= pooled_s;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_frame_last = out_last_q;

endmodule
